// File: rtl/regfile_port_scheduler_if.sv
// Decode/writeback request ports and register-file control bundle for the
// register-file port scheduler.
interface regfile_port_scheduler_if;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    logic          rd_valid;
    logic [AW-1:0] rd_ra;
    logic [AW-1:0] rd_rb;
    logic          rd_ready;
    logic          rd_resp_valid;

    logic          wb_valid;
    logic [AW-1:0] wb_rw;
    logic [DW-1:0] wb_data;
    logic          wb_dual;
    logic [AW-1:0] wb_ra;
    logic [DW-1:0] wb_data1;
    logic          wb_ready;

    logic [AW-1:0] rf_ra;
    logic [AW-1:0] rf_rb;
    logic [AW-1:0] rf_rw;
    logic [DW-1:0] rf_bus_w;
    logic [DW-1:0] rf_bus_w1;
    logic          rf_regrw;
    logic          rf_rs1rw;

    modport master (
        output rd_valid, rd_ra, rd_rb,
        output wb_valid, wb_rw, wb_data, wb_dual, wb_ra, wb_data1,
        input  rd_ready, rd_resp_valid, wb_ready,
        input  rf_ra, rf_rb, rf_rw, rf_bus_w, rf_bus_w1, rf_regrw, rf_rs1rw
    );

    modport slave (
        input  rd_valid, rd_ra, rd_rb,
        input  wb_valid, wb_rw, wb_data, wb_dual, wb_ra, wb_data1,
        output rd_ready, rd_resp_valid, wb_ready,
        output rf_ra, rf_rb, rf_rw, rf_bus_w, rf_bus_w1, rf_regrw, rf_rs1rw
    );
endinterface

// File: rtl/regfile_port_scheduler.sv
// Arbitrates decode reads and writeback (single/dual) writes into one
// registered register-file issue slot per cycle, with bounded write priority.
module regfile_port_scheduler #(
    parameter int unsigned STARVE_LIMIT = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    regfile_port_scheduler_if.slave bus
);
    localparam int unsigned CW = 3;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        SLOT_NONE  = 2'd0,
        SLOT_READ  = 2'd1,
        SLOT_WRITE = 2'd2,
        SLOT_DUAL  = 2'd3
    } slot_e;

    slot_e         r_slot;
    slot_e         w_slot_nxt;
    logic [CW-1:0] r_starve;
    logic [CW-1:0] w_starve_nxt;
    logic          w_wb_grant;
    logic          w_rd_grant;
    logic          w_collide;

    logic [AW-1:0] r_ra, r_rb, r_rw;
    logic [DW-1:0] r_bus_w, r_bus_w1;
    logic          r_regrw, r_rs1rw, r_resp_valid;

    logic [AW-1:0] w_ra_nxt, w_rb_nxt, w_rw_nxt;
    logic [DW-1:0] w_bus_w_nxt, w_bus_w1_nxt;
    logic          w_regrw_nxt, w_rs1rw_nxt, w_resp_valid_nxt;

    // State and issue registers; reset drops whatever was in the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot       <= SLOT_NONE;
            r_starve     <= '0;
            r_ra         <= '0;
            r_rb         <= '0;
            r_rw         <= '0;
            r_bus_w      <= '0;
            r_bus_w1     <= '0;
            r_regrw      <= 1'b0;
            r_rs1rw      <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_slot       <= w_slot_nxt;
            r_starve     <= w_starve_nxt;
            r_ra         <= w_ra_nxt;
            r_rb         <= w_rb_nxt;
            r_rw         <= w_rw_nxt;
            r_bus_w      <= w_bus_w_nxt;
            r_bus_w1     <= w_bus_w1_nxt;
            r_regrw      <= w_regrw_nxt;
            r_rs1rw      <= w_rs1rw_nxt;
            r_resp_valid <= w_resp_valid_nxt;
        end
    end

    // Arbitration: writes win until a waiting read has seen STARVE_LIMIT write grants
    always_comb begin
        w_wb_grant   = 1'b0;
        w_rd_grant   = 1'b0;
        w_slot_nxt   = SLOT_NONE;
        w_starve_nxt = r_starve;
        w_collide    = bus.wb_dual && (bus.wb_ra == bus.wb_rw);
        if (rst_n) begin
            w_wb_grant = bus.wb_valid && !(bus.rd_valid && (r_starve == CW'(STARVE_LIMIT)));
            w_rd_grant = bus.rd_valid && !w_wb_grant;
        end
        if (w_wb_grant) begin
            w_slot_nxt = (bus.wb_dual && !w_collide) ? SLOT_DUAL : SLOT_WRITE;
        end else if (w_rd_grant) begin
            w_slot_nxt = SLOT_READ;
        end
        if (!bus.rd_valid || w_rd_grant) begin
            w_starve_nxt = '0;
        end else if (w_wb_grant) begin
            w_starve_nxt = r_starve + CW'(1);
        end
    end

    // Register-file controls for the op entering the slot; addresses and data hold otherwise
    always_comb begin
        w_ra_nxt         = r_ra;
        w_rb_nxt         = r_rb;
        w_rw_nxt         = r_rw;
        w_bus_w_nxt      = r_bus_w;
        w_bus_w1_nxt     = r_bus_w1;
        w_regrw_nxt      = 1'b0;
        w_rs1rw_nxt      = 1'b0;
        w_resp_valid_nxt = (r_slot == SLOT_READ);
        case (w_slot_nxt)
            SLOT_READ: begin
                w_ra_nxt = bus.rd_ra;
                w_rb_nxt = bus.rd_rb;
            end
            SLOT_WRITE: begin
                w_rw_nxt    = bus.wb_rw;
                w_bus_w_nxt = bus.wb_data;
                w_regrw_nxt = 1'b1;
            end
            SLOT_DUAL: begin
                w_rw_nxt     = bus.wb_rw;
                w_bus_w_nxt  = bus.wb_data;
                w_ra_nxt     = bus.wb_ra;
                w_bus_w1_nxt = bus.wb_data1;
                w_regrw_nxt  = 1'b1;
                w_rs1rw_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.rd_ready      = w_rd_grant;
    assign bus.wb_ready      = w_wb_grant;
    assign bus.rd_resp_valid = r_resp_valid;
    assign bus.rf_ra         = r_ra;
    assign bus.rf_rb         = r_rb;
    assign bus.rf_rw         = r_rw;
    assign bus.rf_bus_w      = r_bus_w;
    assign bus.rf_bus_w1     = r_bus_w1;
    assign bus.rf_regrw      = r_regrw;
    assign bus.rf_rs1rw      = r_rs1rw;
endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Bench for regfile_port_scheduler: register-file stand-in, architectural
// reference model, directed scenarios and a randomized mixed-traffic phase.
module tb_regfile_port_scheduler;
    localparam int unsigned LIMIT = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_port_scheduler_if bus ();

    regfile_port_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Register-file stand-in driven by the scheduler's controls
    logic [31:0] rf_mem [16] = '{default: 32'h0};
    logic [31:0] bus_a, bus_b;
    always @(posedge clk) begin
        if (bus.rf_regrw) rf_mem[bus.rf_rw] <= bus.rf_bus_w;
        if (bus.rf_rs1rw) rf_mem[bus.rf_ra] <= bus.rf_bus_w1;
        bus_a <= rf_mem[bus.rf_ra];
        bus_b <= rf_mem[bus.rf_rb];
    end

    int total = 0;
    int bad   = 0;

    // Reference model: architectural registers, starvation count, expected pipeline
    logic [31:0] m_regs [16] = '{default: 32'h0};
    int          m_starve = 0;
    logic        pw_v = 1'b0, pw_v1 = 1'b0;
    logic [3:0]  pw_rw, pw_ra;
    logic [31:0] pw_d, pw_d1;
    logic        s1_v = 1'b0, rsp_v = 1'b0;
    logic [31:0] s1_a, s1_b, rsp_a, rsp_b;
    logic        obs_wg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic randomize_inputs();
        bus.rd_valid = 1'($urandom);
        bus.rd_ra    = 4'($urandom);
        bus.rd_rb    = 4'($urandom);
        bus.wb_valid = 1'($urandom);
        bus.wb_rw    = 4'($urandom);
        bus.wb_data  = $urandom;
        bus.wb_dual  = 1'($urandom);
        bus.wb_ra    = 4'($urandom);
        bus.wb_data1 = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_ready"}, 32'(bus.rd_ready), 32'd0);
        chk({tag, "_wb_ready"}, 32'(bus.wb_ready), 32'd0);
        chk({tag, "_resp"},     32'(bus.rd_resp_valid), 32'd0);
        chk({tag, "_regrw"},    32'(bus.rf_regrw), 32'd0);
        chk({tag, "_rs1rw"},    32'(bus.rf_rs1rw), 32'd0);
        chk({tag, "_addr"},     32'({bus.rf_ra, bus.rf_rb, bus.rf_rw}), 32'd0);
        chk({tag, "_bus_w"},    bus.rf_bus_w, 32'd0);
        chk({tag, "_bus_w1"},   bus.rf_bus_w1, 32'd0);
    endtask

    // Called just after a falling edge: asserts reset mid-cycle, holds it, releases mid-cycle
    task automatic do_reset(input int hold);
        #2 rst_n = 1'b0;
        randomize_inputs();
        #1 chk_all_zero("rst_assert");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            randomize_inputs();
            #1 chk_all_zero("rst_hold");
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        pw_v = 1'b0; pw_v1 = 1'b0; s1_v = 1'b0; rsp_v = 1'b0; m_starve = 0;
    endtask

    // One clock of traffic: check registered outputs, drive, check grants, advance the model
    task automatic cycle(input logic rv, input logic [3:0] ra, input logic [3:0] rb,
                         input logic wv, input logic [3:0] rw, input logic [31:0] d,
                         input logic dl, input logic [3:0] ra2, input logic [31:0] d1);
        logic wg, rg;
        chk("regrw", 32'(bus.rf_regrw), 32'(pw_v));
        chk("rs1rw", 32'(bus.rf_rs1rw), 32'(pw_v1));
        if (pw_v) begin
            chk("rf_rw", 32'(bus.rf_rw), 32'(pw_rw));
            chk("rf_bus_w", bus.rf_bus_w, pw_d);
        end
        if (pw_v1) begin
            chk("rf_ra_dual", 32'(bus.rf_ra), 32'(pw_ra));
            chk("rf_bus_w1", bus.rf_bus_w1, pw_d1);
        end
        chk("resp_valid", 32'(bus.rd_resp_valid), 32'(rsp_v));
        if (rsp_v) begin
            chk("bus_a", bus_a, rsp_a);
            chk("bus_b", bus_b, rsp_b);
        end
        if (pw_v)  m_regs[pw_rw] = pw_d;
        if (pw_v1) m_regs[pw_ra] = pw_d1;

        bus.rd_valid = rv;  bus.rd_ra = ra;   bus.rd_rb = rb;
        bus.wb_valid = wv;  bus.wb_rw = rw;   bus.wb_data = d;
        bus.wb_dual  = dl;  bus.wb_ra = ra2;  bus.wb_data1 = d1;
        #1;
        wg = wv && !(rv && (m_starve == int'(LIMIT)));
        rg = rv && !wg;
        chk("wb_ready", 32'(bus.wb_ready), 32'(wg));
        chk("rd_ready", 32'(bus.rd_ready), 32'(rg));
        obs_wg = bus.wb_ready;

        rsp_v = s1_v; rsp_a = s1_a; rsp_b = s1_b;
        s1_v  = rg;
        if (rg) begin
            s1_a = m_regs[ra];
            s1_b = m_regs[rb];
        end
        pw_v  = wg;
        pw_v1 = wg && dl && (ra2 != rw);
        pw_rw = rw; pw_d = d; pw_ra = ra2; pw_d1 = d1;
        if (!rv || rg) m_starve = 0;
        else if (wg)   m_starve = m_starve + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        bus.rd_valid = 1'b0; bus.rd_ra = '0; bus.rd_rb = '0;
        bus.wb_valid = 1'b0; bus.wb_rw = '0; bus.wb_data = '0;
        bus.wb_dual  = 1'b0; bus.wb_ra = '0; bus.wb_data1 = '0;
        @(negedge clk);
        do_reset(3);

        // Single write then read
        cycle(1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
        chk("w3_regrw_pulse", 32'(bus.rf_regrw), 32'd1);
        cycle(1'b1, 4'd3, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        chk("w3_regrw_drop", 32'(bus.rf_regrw), 32'd0);
        idle();
        chk("r3_resp", 32'(bus.rd_resp_valid), 32'd1);
        chk("r3_bus_a", bus_a, 32'hDEADBEEF);
        chk("r3_bus_b", bus_b, 32'd0);
        idle();

        // Dual write then read both targets
        cycle(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 32'h11, 1'b1, 4'd2, 32'h22);
        chk("dual_rs1rw", 32'(bus.rf_rs1rw), 32'd1);
        cycle(1'b1, 4'd5, 4'd2, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        chk("dual_rs1rw_drop", 32'(bus.rf_rs1rw), 32'd0);
        idle();
        chk("dual_r5", bus_a, 32'h11);
        chk("dual_r2", bus_b, 32'h22);
        idle();

        // Dual-write collision: primary data wins
        cycle(1'b0, 4'd0, 4'd0, 1'b1, 4'd7, 32'hA, 1'b1, 4'd7, 32'hB);
        chk("coll_rs1rw", 32'(bus.rf_rs1rw), 32'd0);
        chk("coll_regrw", 32'(bus.rf_regrw), 32'd1);
        cycle(1'b1, 4'd7, 4'd7, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        idle();
        chk("coll_r7", bus_a, 32'hA);
        idle();

        // Starvation bound with both requesters continuously valid
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 4'(i), 4'(i + 1), 1'b1, 4'(8 + (i % 4)), $urandom, 1'b0, 4'd0, 32'd0);
            chk("starve_pattern", 32'(obs_wg), 32'((i % (LIMIT + 1)) != LIMIT));
        end
        idle();
        idle();

        // Reset in the cycle after a write grant: write is lost, outputs drop at once
        cycle(1'b1, 4'd1, 4'd2, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        cycle(1'b0, 4'd0, 4'd0, 1'b1, 4'd12, 32'h12345678, 1'b0, 4'd0, 32'd0);
        chk("pre_rst_regrw", 32'(bus.rf_regrw), 32'd1);
        chk("pre_rst_resp", 32'(bus.rd_resp_valid), 32'd1);
        do_reset(1);
        cycle(1'b1, 4'd12, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        idle();
        chk("rst_r12_unchanged", bus_a, m_regs[12]);
        idle();

        // Randomized mixed traffic
        for (int i = 0; i < 300; i++) begin
            logic [3:0] rw, ra2;
            rw  = 4'($urandom);
            ra2 = ($urandom_range(0, 3) == 0) ? rw : 4'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 4) < 3), rw, $urandom,
                  1'($urandom), ra2, $urandom);
        end
        idle();
        idle();

        // Read back the whole file
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'(2 * i), 4'(2 * i + 1), 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        end
        idle();
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
